// File: rtl/shot_hit_if.sv
// Signal bundle between the shot/duck producers and shot_hit_detector.
// The master drives the shot slots, duck position and strobes. The slave reports hits, the score and its FSM state.
interface shot_hit_if;
  logic        frame_tick;
  logic [79:0] shots_x;
  logic [79:0] shots_y;
  logic [7:0]  shots_valid;
  logic [9:0]  duck_x;
  logic [9:0]  duck_y;
  logic        duck_respawn;
  logic        hit;
  logic [2:0]  hit_index;
  logic [7:0]  shot_clear;
  logic        duck_dead;
  logic        scan_done;
  logic [7:0]  score;
  logic [1:0]  state_dbg;

  // Level inputs are sampled on every clk edge. frame_tick and duck_respawn are
  // single-cycle strobes with no ready/accept. They are dropped when the FSM is not in a state that uses them.
  modport master (
    output frame_tick, shots_x, shots_y, shots_valid, duck_x, duck_y, duck_respawn,
    input  hit, hit_index, shot_clear, duck_dead, scan_done, score, state_dbg
  );

  modport slave (
    input  frame_tick, shots_x, shots_y, shots_valid, duck_x, duck_y, duck_respawn,
    output hit, hit_index, shot_clear, duck_dead, scan_done, score, state_dbg
  );
endinterface

// File: rtl/shot_hit_detector.sv
// Once per frame, tests the 8 shot slots in order against the latched duck box and reports the first hit.
// Define SCORE_BCD_EN to make the score a saturating 2-digit BCD count (00..99).
module shot_hit_detector #(
  parameter int SHOT_W    = 2,
  parameter int SHOT_H    = 10,
  parameter int DUCK_W    = 32,
  parameter int DUCK_H    = 32,
  parameter int SCORE_MAX = 99
) (
  input logic       clk,
  input logic       reset,
  shot_hit_if.slave sh
);

  typedef enum logic [1:0] {IDLE, SCAN, REPORT, DEAD} state_t;

  state_t      state, state_nxt;
  logic [2:0]  idx, idx_nxt;
  logic [2:0]  hit_idx_q;
  logic [9:0]  dx_q, dy_q;
  logic        scan_done_q;
  logic [7:0]  score_q;
  logic        capture, done_set, slot_hit;

  logic signed [11:0] sx, sy, dx, dy;

  // x is unsigned and y is signed. Widening to 12 bits keeps box edges near 0 and 1023 from wrapping.
  always_comb begin
    sx = signed'({2'b00, sh.shots_x[int'(idx)*10 +: 10]});
    sy = signed'({{2{sh.shots_y[int'(idx)*10 + 9]}}, sh.shots_y[int'(idx)*10 +: 10]});
    dx = signed'({2'b00, dx_q});
    dy = signed'({{2{dy_q[9]}}, dy_q});
    slot_hit = sh.shots_valid[idx]
            && (sx <= dx + 12'(DUCK_W - 1))
            && (sx + 12'(SHOT_W - 1) >= dx)
            && (sy <= dy + 12'(DUCK_H - 1))
            && (sy + 12'(SHOT_H - 1) >= dy);
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    capture   = 1'b0;
    done_set  = 1'b0;
    case (state)
      IDLE: begin
        if (sh.frame_tick) begin
          state_nxt = SCAN;
          idx_nxt   = 3'd0;
        end
      end
      SCAN: begin
        // A respawn while scanning abandons the frame without reporting anything.
        if (sh.duck_respawn) begin
          state_nxt = IDLE;
        end else if (slot_hit) begin
          state_nxt = REPORT;
          capture   = 1'b1;
        end else if (idx == 3'd7) begin
          state_nxt = IDLE;
          done_set  = 1'b1;
        end else begin
          idx_nxt = idx + 3'd1;
        end
      end
      REPORT: state_nxt = DEAD;
      DEAD: begin
        if (sh.duck_respawn) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= 3'd0;
      hit_idx_q   <= 3'd0;
      dx_q        <= 10'd0;
      dy_q        <= 10'd0;
      scan_done_q <= 1'b0;
      score_q     <= 8'd0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      scan_done_q <= done_set;
      if (state == IDLE && sh.frame_tick) begin
        dx_q <= sh.duck_x;
        dy_q <= sh.duck_y;
      end
      if (capture) hit_idx_q <= idx;
      if (state == REPORT) begin
`ifdef SCORE_BCD_EN
        if (score_q != 8'h99) begin
          if (score_q[3:0] == 4'd9) score_q <= {score_q[7:4] + 4'd1, 4'd0};
          else                      score_q <= {score_q[7:4], score_q[3:0] + 4'd1};
        end
`else
        if (score_q < 8'(SCORE_MAX)) score_q <= score_q + 8'd1;
`endif
      end
    end
  end

  assign sh.hit        = (state == REPORT);
  assign sh.hit_index  = hit_idx_q;
  assign sh.shot_clear = (state == REPORT) ? (8'd1 << hit_idx_q) : 8'd0;
  assign sh.duck_dead  = (state == DEAD);
  assign sh.scan_done  = scan_done_q;
  assign sh.score      = score_q;
  assign sh.state_dbg  = state;

endmodule
